// File: rtl/mul_add_unit_pkg.sv
// Shared definitions for the picoMips ALU arithmetic datapath:
// operation encoding and default operand geometry.
package alu_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_FRAC  = 3;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_MUL  = 2'b01,
        OP_FMUL = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

endpackage

// File: rtl/mul_add_unit_if.sv
// Request/result bundle between the ALU controller (master) and mul_add_unit (slave).
interface mul_add_unit_if #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH
);
    import alu_pkg::*;

    logic             in_valid;
    op_e              op;
    logic             en_a;
    logic             en_b;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             out_valid;

    modport master (
        output in_valid, op, en_a, en_b, a, b,
        input  result, out_valid
    );

    modport slave (
        input  in_valid, op, en_a, en_b, a, b,
        output result, out_valid
    );

endinterface

// File: rtl/mul_add_unit_mult.sv
// Combinational WIDTH x WIDTH signed multiplier returning the full 2*WIDTH product.
module signed_mult #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] prod_o
);

    logic signed [2*WIDTH-1:0] a_ext_s;
    logic signed [2*WIDTH-1:0] b_ext_s;

    assign a_ext_s = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i});
    assign b_ext_s = $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
    assign prod_o  = a_ext_s * b_ext_s;

endmodule

// File: rtl/mul_add_unit.sv
// Signed add / integer multiply / fixed-point multiply on gated operands,
// with either a combinational or a single registered output stage.
module mul_add_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int FRAC    = DEF_FRAC,
    parameter int LATENCY = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mul_add_unit_if.slave      bus
);

    localparam bit COMB_OUT = (LATENCY == 0);

    logic        [WIDTH-1:0]   a_s;
    logic        [WIDTH-1:0]   b_s;
    logic        [2*WIDTH-1:0] prod_s;
    logic signed [2*WIDTH-1:0] prod_signed_s;
    logic        [WIDTH-1:0]   sum_s;
    logic        [WIDTH-1:0]   result_s;
    logic        [WIDTH-1:0]   result_d;
    logic        [WIDTH-1:0]   result_q;
    logic                      valid_d;
    logic                      valid_q;

    // A disabled operand is a hard zero, never the raw bus value.
    assign a_s   = bus.en_a ? bus.a : {WIDTH{1'b0}};
    assign b_s   = bus.en_b ? bus.b : {WIDTH{1'b0}};
    assign sum_s = a_s + b_s;

    signed_mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .a_i    (a_s),
        .b_i    (b_s),
        .prod_o (prod_s)
    );

    assign prod_signed_s = $signed(prod_s);

    // Result select; FMUL is an arithmetic shift so negatives floor toward minus infinity.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        case (bus.op)
            OP_ADD:  result_s = sum_s;
            OP_MUL:  result_s = WIDTH'(prod_signed_s);
            OP_FMUL: result_s = WIDTH'(prod_signed_s >>> FRAC);
            OP_RSVD: result_s = {WIDTH{1'b0}};
            default: result_s = {WIDTH{1'b0}};
        endcase
    end

    // Next state of the output stage: capture on a valid request, otherwise hold the data.
    always_comb begin
        result_d = result_q;
        valid_d  = 1'b0;
        if (bus.in_valid) begin
            result_d = result_s;
            valid_d  = 1'b1;
        end else begin
            result_d = result_q;
            valid_d  = 1'b0;
        end
    end

    // Output stage register; reset wins over any request on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    // The register only reaches the outputs in the one-cycle configuration.
    assign bus.result    = COMB_OUT ? result_s : result_q;
    assign bus.out_valid = COMB_OUT ? bus.in_valid : valid_q;

endmodule

// File: tb/tb_mul_add_unit.sv
// Self-checking bench: a combinational and a one-stage instance of mul_add_unit
// (WIDTH=8, FRAC=3) checked against directed tables and a plain-arithmetic model.
module tb_mul_add_unit;
    import alu_pkg::*;

    logic clk;
    logic rst0;
    logic rst1;
    int   n_vec;
    int   n_err;

    mul_add_unit_if #(.WIDTH(8)) if0 ();
    mul_add_unit_if #(.WIDTH(8)) if1 ();

    mul_add_unit #(.WIDTH(8), .FRAC(3), .LATENCY(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst0),
        .bus   (if0.slave)
    );

    mul_add_unit #(.WIDTH(8), .FRAC(3), .LATENCY(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst1),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic       en_a;
        logic       en_b;
        logic [7:0] a;
        logic [7:0] b;
        logic       inv;
        logic [7:0] eo;
        logic       ev;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [7:0] ref_out(input logic [1:0] op, input logic ea, input logic eb,
                                           input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        int p;
        sa = ea ? int'($signed(a)) : 0;
        sb = eb ? int'($signed(b)) : 0;
        case (op)
            2'd0:    p = sa + sb;
            2'd1:    p = sa * sb;
            2'd2:    p = (sa * sb) >>> 3;
            default: p = 0;
        endcase
        return p[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act_o, input logic act_v,
                         input logic [7:0] exp_o, input logic exp_v);
        n_vec++;
        if (act_o !== exp_o || act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got out=%h valid=%b, expected out=%h valid=%b",
                     name, act_o, act_v, exp_o, exp_v);
        end
    endtask

    task automatic drive0(input logic [1:0] op, input logic ea, input logic eb,
                          input logic [7:0] a, input logic [7:0] b, input logic inv);
        if0.op = op_e'(op); if0.en_a = ea; if0.en_b = eb;
        if0.a = a; if0.b = b; if0.in_valid = inv;
    endtask

    task automatic drive1(input logic rst, input logic [1:0] op, input logic ea, input logic eb,
                          input logic [7:0] a, input logic [7:0] b, input logic inv);
        rst1 = rst;
        if1.op = op_e'(op); if1.en_a = ea; if1.en_b = eb;
        if1.a = a; if1.b = b; if1.in_valid = inv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_o;
        logic       exp_v;
        logic       r;
        logic [1:0] op;
        logic       ea;
        logic       eb;
        logic [7:0] a;
        logic [7:0] b;
        logic       inv;

        n_vec = 0;
        n_err = 0;
        rst0  = 1'b0;
        drive0(2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive1(1'b1, 2'd0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1);

        tbl[0]  = '{2'd0, 1'b1, 1'b1, 8'h05, 8'hFD, 1'b1, 8'h02, 1'b1};
        tbl[1]  = '{2'd0, 1'b1, 1'b1, 8'h05, 8'hFD, 1'b0, 8'h02, 1'b0};
        tbl[2]  = '{2'd0, 1'b0, 1'b1, 8'h05, 8'hFD, 1'b1, 8'hFD, 1'b1};
        tbl[3]  = '{2'd0, 1'b0, 1'b0, 8'h05, 8'hFD, 1'b1, 8'h00, 1'b1};
        tbl[4]  = '{2'd0, 1'b1, 1'b1, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b1};
        tbl[5]  = '{2'd0, 1'b1, 1'b1, 8'h80, 8'hFF, 1'b1, 8'h7F, 1'b1};
        tbl[6]  = '{2'd1, 1'b1, 1'b1, 8'h01, 8'h5A, 1'b1, 8'h5A, 1'b1};
        tbl[7]  = '{2'd1, 1'b1, 1'b1, 8'hFD, 8'h07, 1'b1, 8'hEB, 1'b1};
        tbl[8]  = '{2'd1, 1'b1, 1'b1, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1};
        tbl[9]  = '{2'd1, 1'b1, 1'b0, 8'h05, 8'h07, 1'b1, 8'h00, 1'b1};
        tbl[10] = '{2'd2, 1'b1, 1'b1, 8'h14, 8'h08, 1'b1, 8'h14, 1'b1};
        tbl[11] = '{2'd2, 1'b1, 1'b1, 8'h0C, 8'h0C, 1'b1, 8'h12, 1'b1};
        tbl[12] = '{2'd2, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, 8'hFF, 1'b1};
        tbl[13] = '{2'd2, 1'b1, 1'b1, 8'h80, 8'h08, 1'b1, 8'h80, 1'b1};
        tbl[14] = '{2'd3, 1'b1, 1'b1, 8'h05, 8'h07, 1'b1, 8'h00, 1'b1};
        tbl[15] = '{2'd2, 1'b0, 1'b1, 8'h14, 8'h08, 1'b1, 8'h00, 1'b1};

        // Directed table on the combinational instance.
        for (int i = 0; i < 16; i++) begin
            drive0(tbl[i].op, tbl[i].en_a, tbl[i].en_b, tbl[i].a, tbl[i].b, tbl[i].inv);
            #1;
            check($sformatf("l0_tbl%0d", i), if0.result, if0.out_valid, tbl[i].eo, tbl[i].ev);
        end

        // Random stimulus on the combinational instance against the model.
        for (int i = 0; i < 200; i++) begin
            op  = 2'($urandom_range(0, 3));
            ea  = ($urandom_range(0, 7) != 0);
            eb  = ($urandom_range(0, 7) != 0);
            a   = 8'($urandom);
            b   = 8'($urandom);
            inv = 1'($urandom);
            drive0(op, ea, eb, a, b, inv);
            #1;
            check($sformatf("l0_rnd%0d", i), if0.result, if0.out_valid, ref_out(op, ea, eb, a, b), inv);
        end

        // Registered instance: reset held for two edges with a valid request present.
        step();
        check("l1_rst_edge1", if1.result, if1.out_valid, 8'h00, 1'b0);
        step();
        check("l1_rst_edge2", if1.result, if1.out_valid, 8'h00, 1'b0);

        drive1(1'b0, 2'd1, 1'b1, 1'b1, 8'h03, 8'h04, 1'b1);
        step();
        check("l1_mul_3x4", if1.result, if1.out_valid, 8'h0C, 1'b1);

        drive1(1'b0, 2'd0, 1'b1, 1'b1, 8'h55, 8'h21, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("l1_hold%0d", i), if1.result, if1.out_valid, 8'h0C, 1'b0);
        end

        drive1(1'b0, 2'd0, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
        step();
        check("l1_b2b_add1", if1.result, if1.out_valid, 8'h02, 1'b1);
        drive1(1'b0, 2'd0, 1'b1, 1'b1, 8'h02, 8'h02, 1'b1);
        step();
        check("l1_b2b_add2", if1.result, if1.out_valid, 8'h04, 1'b1);

        drive1(1'b1, 2'd2, 1'b1, 1'b1, 8'h14, 8'h08, 1'b1);
        step();
        check("l1_rst_prio", if1.result, if1.out_valid, 8'h00, 1'b0);

        drive1(1'b0, 2'd0, 1'b1, 1'b1, 8'h05, 8'h07, 1'b1);
        step();
        check("l1_add_5p7", if1.result, if1.out_valid, 8'h0C, 1'b1);
        drive1(1'b0, 2'd3, 1'b1, 1'b1, 8'h05, 8'h07, 1'b1);
        step();
        check("l1_rsvd", if1.result, if1.out_valid, 8'h00, 1'b1);

        // Random stream with occasional resets against a one-stage model.
        exp_o = 8'h00;
        exp_v = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r   = ($urandom_range(0, 15) == 0);
            op  = 2'($urandom_range(0, 3));
            ea  = ($urandom_range(0, 7) != 0);
            eb  = ($urandom_range(0, 7) != 0);
            a   = 8'($urandom);
            b   = 8'($urandom);
            inv = ($urandom_range(0, 3) != 0);
            drive1(r, op, ea, eb, a, b, inv);
            step();
            if (r) begin
                exp_o = 8'h00;
                exp_v = 1'b0;
            end else if (inv) begin
                exp_o = ref_out(op, ea, eb, a, b);
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
            check($sformatf("l1_rnd%0d", i), if1.result, if1.out_valid, exp_o, exp_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_add_unit.md
Name: mul_add_unit

Overview:
- Signed arithmetic datapath for the picoMips ALU.
- Computes one of three operations on two gated operands: add, integer multiply, or fixed-point multiply.
- Output is either combinational or registered once, fixed at elaboration.
- The ALU builds its accumulator update from this block; an add-only or multiply-only configuration is a subset.

Parameters:
- WIDTH, 8, operand and result width in bits (two's complement).
- FRAC, 3, fractional bits for the fixed-point multiply; legal range 0..WIDTH-1.
- LATENCY, 0, 0 = combinational output, 1 = one registered stage.

Ports:
- Clock  input  1  rising-edge clock; unused when LATENCY=0.
- Reset  input  1  synchronous, active-high reset; unused when LATENCY=0.
- InValid  input  1  operands and Op are valid this cycle.
- Op  input  2  00 ADD, 01 MUL, 10 FMUL, 11 reserved.
- EnA  input  1  1 = use A, 0 = A operand forced to 0.
- EnB  input  1  1 = use B, 0 = B operand forced to 0.
- A  input  WIDTH  signed operand A.
- B  input  WIDTH  signed operand B.
- Out  output  WIDTH  signed result.
- OutValid  output  1  Out holds a result for a valid request.

Behaviour:
- Gating:
  - a = EnA ? A : 0.
  - b = EnB ? B : 0.
  - Gating applies to every Op.
- ADD: Out = (a + b) mod 2^WIDTH. Wraps, no saturation, no carry or overflow flag.
- MUL:
  - Full 2*WIDTH signed product p = a*b.
  - Out = p[WIDTH-1:0], i.e. the low bits, wrapping.
- FMUL:
  - p = a*b as above.
  - Out = p[FRAC+WIDTH-1:FRAC], which is an arithmetic shift right by FRAC (rounds toward minus infinity) truncated to WIDTH.
  - No rounding, no saturation.
  - With FRAC=3, B=8 represents 1.0, so A*8 returns A for all A.
- Op=11 (reserved): Out = 0.
- LATENCY=0:
  - Out is a pure function of the current inputs.
  - OutValid = InValid.
  - No state is held.
- LATENCY=1:
  - On each rising Clock edge with Reset=1: Out <= 0, OutValid <= 0. Reset has priority over everything.
  - Otherwise, if InValid=1: Out <= result, OutValid <= 1.
  - Otherwise: Out holds its value, OutValid <= 0.
  - Latency is one cycle; throughput is one result per cycle; there is no backpressure.
  - Reset asserted mid-stream discards the in-flight result on that edge.
  - Inputs present in the cycle Reset deasserts are captured on the next edge only if InValid=1.
- Reset values (LATENCY=1): Out = 0, OutValid = 0.
- No X propagation from gated-off operands: a gated operand contributes exactly 0.

Decomposition:
- Shared package alu_pkg holds:
  - Op encoding enum (OP_ADD, OP_MUL, OP_FMUL, OP_RSVD).
  - Default WIDTH and FRAC constants.
- One sub-module, signed_mult: combinational WIDTH x WIDTH signed multiplier returning the full 2*WIDTH product, shared by MUL and FMUL.
- Operand gating, add path, result mux and the optional register stay in mul_add_unit.

Test Plan:
All cases use WIDTH=8, FRAC=3.
- ADD and gating (LATENCY=0):
  - A=5, B=-3, EnA=EnB=1 -> Out=2, OutValid follows InValid.
  - EnA=0 -> Out=0xFD.
  - EnA=EnB=0 -> Out=0.
- ADD wrap: A=127, B=1 -> Out=0x80 (-128); A=-128, B=-1 -> Out=0x7F.
- MUL:
  - A=1, B=0x5A -> 0x5A.
  - A=-3, B=7 -> 0xEB (-21).
  - A=16, B=16 -> 0x00 (256 wraps).
  - EnB=0 -> 0.
- FMUL:
  - A=20, B=8 -> 20.
  - A=12, B=12 -> 18 (1.5*1.5 = 2.25).
  - A=-1, B=1 -> 0xFF (floor).
  - A=-128, B=8 -> 0x80.
- LATENCY=1 timing:
  - Reset high for 2 edges -> Out=0, OutValid=0.
  - MUL 3*4 with InValid=1 -> next edge Out=12, OutValid=1.
  - InValid=0 for 3 cycles -> Out stays 12, OutValid=0.
  - Back-to-back InValid ADD 1+1, then 2+2 -> 2 then 4 on consecutive edges.
- LATENCY=1 reset priority: Reset=1 and InValid=1 on the same edge (FMUL 20*8) -> Out=0, OutValid=0. Op=11 with InValid=1 -> Out=0, OutValid=1.
